debug_trace_fifo: RTL and testbench
===================================

# debug_trace_fifo

Parametrised multi-channel commit-trace buffer between the CPU's retire stage and the debug/difftest drain port. It accepts up to NUM_CH trace records per cycle, packs them in channel order into a circular buffer, and returns them one per cycle under a valid/ready handshake. A selectable overflow policy either back-pressures retire or drops and counts records. Occupancy and loss statistics are exported.

## Interface
- DATA_W, 102: trace record width in bits
- NUM_CH, 2: write channels per cycle, 1..4
- DEPTH_LOG2, 10: buffer depth = 2**DEPTH_LOG2 entries, must satisfy 2**DEPTH_LOG2 >= 2*NUM_CH
- DROP_MODE, 0: 0 = stall (back-pressure), 1 = drop-newest
- CNT_W, 16: width of drop counter
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- in_valid  in  NUM_CH  per-channel record valid
- in_ready  out  1  common ready for all channels; a channel transfers when in_valid[i] & in_ready
- out_data  out  DATA_W  head record, first-word-fall-through
- out_valid  out  1  buffer non-empty
- out_ready  in  1  consumer takes head this cycle
- count  out  DEPTH_LOG2+1  current occupancy
- full  out  1  count == 2**DEPTH_LOG2
- overflow  out  1  sticky: at least one record dropped since reset or clear
- drop_cnt  out  CNT_W  records dropped, saturating at all-ones
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt

## Operation
- Pointers wr_ptr, rd_ptr are DEPTH_LOG2+1 bits; MSB distinguishes full from empty; low bits index memory and wrap naturally.
- Packing: valid channels are compacted in ascending index; k-th valid channel writes mem[wr_ptr+k]. wr_ptr advances by number accepted (0..NUM_CH).
- Pop: out_valid & out_ready advances rd_ptr by 1. Memory contents are not cleared on pop or reset.
- free = 2**DEPTH_LOG2 - count, evaluated on registered state at cycle start; a same-cycle pop does not increase free.
- DROP_MODE=0: in_ready = (free >= NUM_CH); when 0, no channel is written; nothing ever dropped, overflow/drop_cnt stay 0.
- DROP_MODE=1: in_ready tied 1. If valid count v > free, the lowest-index `free` valid channels are written, remaining v-free dropped; drop_cnt += v-free (saturating), overflow set.
- clr_ovf has priority over a same-cycle increment: both cleared, that cycle's drops not counted.
- Simultaneous push and pop: count = count + accepted - popped, single update.

## Timing
- Reset values: in_ready = 1 (DROP_MODE=1) or 1 (DROP_MODE=0, empty), out_valid 0, out_data don't-care, count 0, full 0, overflow 0, drop_cnt 0, pointers 0.
- Write latency: record accepted at edge N is visible on out_data/out_valid after edge N (1 cycle), if it is the head.
- out_data combinationally reads mem[rd_ptr]; stable while out_valid & !out_ready.
- Reset mid-operation: asserting rst empties buffer immediately (asynchronous), pending records lost, counters zeroed.
- Wrap-around: writes spanning index 2**DEPTH_LOG2-1 to 0 in one cycle handled by modular address per slot.

## Structure
- DATA_W default and trace-record field offsets go in shared defines.vh alongside existing debug constants; mode encodings (stall/drop) defined there.
- Sub-module debug_fifo_compact: combinational prefix-count of in_valid producing per-channel slot offset and accepted count, also used for drop arithmetic.
- Top holds memory, pointers, counters.

## Test plan
- NUM_CH=2, depth 8, stall: push A,B same cycle, out_ready=1 -> out_data A then B on consecutive cycles, count 2 then 1 then 0.
- Only in_valid[1]=1 with record C -> C written at slot wr_ptr (no hole), count 1.
- Stall mode, depth 8, out_ready=0, push pairs 4 cycles -> full=1, in_ready=0 after count 8; records order preserved on drain.
- Drop mode, count=7, push 2 -> channel 0 stored, drop_cnt=1, overflow=1; next cycle clr_ovf=1 with another overflow -> drop_cnt 0, overflow 0.
- Wrap: run 20 pairs through depth 8 with random out_ready -> output sequence equals input sequence, no loss in stall mode.
- Deassert rst low mid-stream with count 5 -> out_valid 0, count 0 immediately; post-reset push visible after one edge.

Source files
------------

// File: rtl/debug_trace_fifo_pkg.sv
// Shared constants and types for the commit-trace buffer.
package debug_trace_fifo_pkg;

  localparam int unsigned TRACE_DATA_W = 102;
  // Slot offsets and per-cycle counts: NUM_CH is at most 4, so 0..4 fits in 3 bits.
  localparam int unsigned OFS_W        = 3;

  typedef enum logic {
    MODE_STALL = 1'b0,
    MODE_DROP  = 1'b1
  } trace_mode_e;

endpackage

// File: rtl/debug_fifo_compact.sv
// Prefix count of valid channels: the slot offset for each channel, plus the
// valid and accepted totals when at most `limit` records may be stored.
module debug_fifo_compact
  import debug_trace_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LIM_W  = 11
) (
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [LIM_W-1:0]        limit,
  output logic [NUM_CH*OFS_W-1:0] slot_ofs,
  output logic [NUM_CH-1:0]       accept,
  output logic [OFS_W-1:0]        valid_cnt,
  output logic [OFS_W-1:0]        acc_cnt
);

  localparam int unsigned CW = LIM_W + OFS_W;

  logic [OFS_W-1:0] run;
  logic [OFS_W-1:0] acc;

  always_comb begin
    run      = '0;
    acc      = '0;
    accept   = '0;
    slot_ofs = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot_ofs[i*OFS_W +: OFS_W] = run;
      if (in_valid[i]) begin
        // Only the lowest-index records that still fit are taken.
        if (CW'(run) < CW'(limit)) begin
          accept[i] = 1'b1;
          acc       = acc + 1'b1;
        end
        run = run + 1'b1;
      end
    end
    valid_cnt = run;
    acc_cnt   = acc;
  end

endmodule

// File: rtl/debug_trace_fifo.sv
// Multi-channel commit-trace buffer: packs up to NUM_CH records per cycle into
// a circular buffer and drains one per cycle; stall or drop-newest on overflow.
module debug_trace_fifo
  import debug_trace_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = TRACE_DATA_W,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DROP_MODE  = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH_LOG2:0]      count,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW1   = CNT_W + 1;
  localparam trace_mode_e MODE  = (DROP_MODE != 0) ? MODE_DROP : MODE_STALL;

  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW-1:0]           free, limit;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [NUM_CH*OFS_W-1:0] slot_ofs;
  logic [NUM_CH-1:0]       accept;
  logic [OFS_W-1:0]        valid_cnt, acc_cnt, drop_n;
  logic [DEPTH_LOG2-1:0]   wr_addr [NUM_CH];
  logic [CNT_W:0]          drop_sum;
  logic                    pop;

  assign count     = wr_ptr - rd_ptr;
  assign free      = PW'(DEPTH) - count;
  assign full      = count[DEPTH_LOG2];
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign pop       = out_valid & out_ready;

  assign in_ready  = (MODE == MODE_DROP) ? 1'b1 : (free >= PW'(NUM_CH));
  // A zero limit blocks every channel when stall mode withholds ready.
  assign limit     = in_ready ? free : '0;

  debug_fifo_compact #(
    .NUM_CH (NUM_CH),
    .LIM_W  (PW)
  ) u_compact (
    .in_valid  (in_valid),
    .limit     (limit),
    .slot_ofs  (slot_ofs),
    .accept    (accept),
    .valid_cnt (valid_cnt),
    .acc_cnt   (acc_cnt)
  );

  assign drop_n   = (MODE == MODE_DROP) ? (valid_cnt - acc_cnt) : '0;
  assign drop_sum = {1'b0, drop_cnt} + CW1'(drop_n);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_addr[i] = DEPTH_LOG2'(wr_ptr + PW'(slot_ofs[i*OFS_W +: OFS_W]));
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        mem[wr_addr[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc_cnt);
      rd_ptr <= rd_ptr + PW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_n != '0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_debug_trace_fifo.sv
// Directed bench for debug_trace_fifo: one stall-mode and one drop-mode instance, depth 8.
module tb_debug_trace_fifo;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;

  logic [2*DW-1:0] s_in_data, d_in_data;
  logic [1:0]      s_in_valid, d_in_valid;
  logic            s_in_ready, d_in_ready;
  logic [DW-1:0]   s_out_data, d_out_data;
  logic            s_out_valid, d_out_valid, s_out_ready, d_out_ready;
  logic [3:0]      s_count, d_count;
  logic            s_full, d_full, s_ovf, d_ovf, s_clr, d_clr;
  logic [3:0]      s_drop, d_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debug_trace_fifo #(
    .DATA_W(DW), .NUM_CH(2), .DEPTH_LOG2(3), .DROP_MODE(0), .CNT_W(4)
  ) u_stall (
    .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .count(s_count), .full(s_full),
    .overflow(s_ovf), .drop_cnt(s_drop), .clr_ovf(s_clr)
  );

  debug_trace_fifo #(
    .DATA_W(DW), .NUM_CH(2), .DEPTH_LOG2(3), .DROP_MODE(1), .CNT_W(4)
  ) u_drop (
    .clk(clk), .rst(rst), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .count(d_count), .full(d_full),
    .overflow(d_ovf), .drop_cnt(d_drop), .clr_ovf(d_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_in_data = '0; s_in_valid = '0; s_out_ready = 1'b0; s_clr = 1'b0;
    d_in_data = '0; d_in_valid = '0; d_out_ready = 1'b0; d_clr = 1'b0;
    #2;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", s_count); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", s_out_valid); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready: got %b expected 1", s_in_ready); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", s_full); end
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_d_in_ready: got %b expected 1", d_in_ready); end
    checks++; if ({d_ovf, d_drop} !== 5'd0) begin errors++; $display("FAIL reset_drop_stats: got %b/%0d expected 0/0", d_ovf, d_drop); end
    #5 rst = 1'b1;
    step();
  endtask

  task automatic test_pair_order();
    s_in_data = {16'hBBBB, 16'hAAAA}; s_in_valid = 2'b11;
    step();
    s_in_valid = 2'b00;
    checks++; if (s_count !== 4'd2) begin errors++; $display("FAIL pair_count2: got %0d expected 2", s_count); end
    checks++; if (s_out_data !== 16'hAAAA || s_out_valid !== 1'b1) begin errors++; $display("FAIL pair_head_A: got %h v=%b expected aaaa v=1", s_out_data, s_out_valid); end
    s_out_ready = 1'b1;
    step();
    checks++; if (s_count !== 4'd1 || s_out_data !== 16'hBBBB) begin errors++; $display("FAIL pair_head_B: got %h cnt=%0d expected bbbb cnt=1", s_out_data, s_count); end
    step();
    checks++; if (s_count !== 4'd0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL pair_empty: got cnt=%0d v=%b expected 0/0", s_count, s_out_valid); end
    s_out_ready = 1'b0;
  endtask

  task automatic test_single_ch1();
    s_in_data = {16'hCCCC, 16'hDEAD}; s_in_valid = 2'b10;
    step();
    s_in_valid = 2'b00;
    checks++; if (s_count !== 4'd1 || s_out_data !== 16'hCCCC) begin errors++; $display("FAIL ch1_pack: got %h cnt=%0d expected cccc cnt=1", s_out_data, s_count); end
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL ch1_drain: got %0d expected 0", s_count); end
  endtask

  task automatic test_stall_full();
    for (int k = 0; k < 4; k++) begin
      s_in_data = {16'(16'h0101 + 2*k), 16'(16'h0100 + 2*k)}; s_in_valid = 2'b11;
      step();
    end
    checks++; if (s_count !== 4'd8 || s_full !== 1'b1) begin errors++; $display("FAIL stall_full: got cnt=%0d full=%b expected 8/1", s_count, s_full); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", s_in_ready); end
    s_in_data = {16'hEEEE, 16'hFFFF};
    step();
    s_in_valid = 2'b00;
    checks++; if (s_count !== 4'd8) begin errors++; $display("FAIL stall_blocked: got %0d expected 8", s_count); end
    s_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (s_out_data !== 16'(16'h0100 + k)) begin errors++; $display("FAIL stall_drain_%0d: got %h expected %h", k, s_out_data, 16'(16'h0100 + k)); end
      step();
    end
    s_out_ready = 1'b0;
    checks++; if (s_count !== 4'd0) begin errors++; $display("FAIL stall_drained: got %0d expected 0", s_count); end
  endtask

  task automatic test_drop_overflow();
    for (int k = 0; k < 3; k++) begin
      d_in_data = {16'(16'h0301 + 2*k), 16'(16'h0300 + 2*k)}; d_in_valid = 2'b11;
      step();
    end
    d_in_data = {16'h9999, 16'h0306}; d_in_valid = 2'b01;
    step();
    checks++; if (d_count !== 4'd7) begin errors++; $display("FAIL drop_fill7: got %0d expected 7", d_count); end
    d_in_data = {16'hF00F, 16'hE00E}; d_in_valid = 2'b11;
    step();
    checks++; if (d_count !== 4'd8 || d_drop !== 4'd1 || d_ovf !== 1'b1) begin errors++; $display("FAIL drop_partial: got cnt=%0d drop=%0d ovf=%b expected 8/1/1", d_count, d_drop, d_ovf); end
    d_clr = 1'b1;
    step();
    d_clr = 1'b0; d_in_valid = 2'b00;
    checks++; if (d_drop !== 4'd0 || d_ovf !== 1'b0) begin errors++; $display("FAIL drop_clr_priority: got drop=%0d ovf=%b expected 0/0", d_drop, d_ovf); end
    d_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (d_out_data !== ((k == 7) ? 16'hE00E : 16'(16'h0300 + k))) begin
        errors++; $display("FAIL drop_drain_%0d: got %h expected %h", k, d_out_data, (k == 7) ? 16'hE00E : 16'(16'h0300 + k));
      end
      step();
    end
    d_out_ready = 1'b0;
  endtask

  task automatic test_drop_saturate();
    d_in_valid = 2'b11;
    for (int k = 0; k < 13; k++) begin
      d_in_data = {16'(16'h0501 + 2*k), 16'(16'h0500 + 2*k)};
      step();
    end
    d_in_valid = 2'b00;
    checks++; if (d_drop !== 4'hF || d_ovf !== 1'b1) begin errors++; $display("FAIL drop_saturate: got drop=%0d ovf=%b expected 15/1", d_drop, d_ovf); end
    checks++; if (d_in_ready !== 1'b1 || d_full !== 1'b1) begin errors++; $display("FAIL drop_ready_full: got rdy=%b full=%b expected 1/1", d_in_ready, d_full); end
    d_clr = 1'b1; d_out_ready = 1'b1;
    step();
    d_clr = 1'b0;
    checks++; if (d_drop !== 4'd0 || d_ovf !== 1'b0 || d_count !== 4'd7) begin errors++; $display("FAIL drop_clear_pop: got drop=%0d ovf=%b cnt=%0d expected 0/0/7", d_drop, d_ovf, d_count); end
    for (int k = 0; k < 7; k++) step();
    d_out_ready = 1'b0;
    checks++; if (d_count !== 4'd0) begin errors++; $display("FAIL drop_drained: got %0d expected 0", d_count); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] q[$];
    int pushed = 0;
    int popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
      s_out_ready = 1'($urandom_range(0, 1));
      if (s_out_valid && s_out_ready) begin
        checks++;
        if (q.size() == 0 || s_out_data !== q[0]) begin
          errors++; $display("FAIL wrap_order_%0d: got %h expected %h", popped, s_out_data, (q.size() != 0) ? q[0] : 16'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      if (pushed < 20 && s_in_ready) begin
        s_in_data = {16'(16'h2001 + 2*pushed), 16'(16'h2000 + 2*pushed)};
        s_in_valid = 2'b11;
        q.push_back(16'(16'h2000 + 2*pushed));
        q.push_back(16'(16'h2001 + 2*pushed));
        pushed++;
      end else begin
        s_in_valid = 2'b00;
      end
      step();
    end
    s_in_valid = 2'b00; s_out_ready = 1'b0;
    checks++; if (popped !== 40) begin errors++; $display("FAIL wrap_total: got %0d expected 40", popped); end
  endtask

  task automatic test_reset_mid();
    s_in_data = {16'h0A01, 16'h0A00}; s_in_valid = 2'b11;
    step(); step();
    s_in_valid = 2'b01;
    step();
    s_in_valid = 2'b00;
    checks++; if (s_count !== 4'd5) begin errors++; $display("FAIL rstmid_count5: got %0d expected 5", s_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (s_count !== 4'd0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got cnt=%0d v=%b expected 0/0", s_count, s_out_valid); end
    #1 rst = 1'b1;
    s_in_data = {16'h4444, 16'h3333}; s_in_valid = 2'b11;
    step();
    s_in_valid = 2'b00;
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h3333 || s_count !== 4'd2) begin errors++; $display("FAIL rstmid_push: got %h v=%b cnt=%0d expected 3333/1/2", s_out_data, s_out_valid, s_count); end
  endtask

  initial begin
    test_reset();
    test_pair_order();
    test_single_ch1();
    test_stall_full();
    test_drop_overflow();
    test_drop_saturate();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
